count_display: RTL and testbench
================================

# count_display

Downstream display stage for the 12-bit free-running counter. Continuously samples the 12-bit count and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine. Drives a 4-digit, active-low, multiplexed seven-segment display with leading-zero blanking. Sits between the counter output and the board's anode/segment pins.

## Interface

- `REFRESH_DIV`, 100000: clock cycles each digit stays lit; must be ≥ 2.
- `BLANK_LEADING`, 1: 1 blanks leading zero digits; 0 shows all four digits.

- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `value`  in  12  binary count from the upstream counter.
- `bcd`  out  16  last completed conversion: {thousands, hundreds, tens, ones}, one nibble each.
- `valid`  out  1  one-cycle pulse when `bcd` updates.
- `busy`  out  1  high while a conversion is in progress.
- `an`  out  4  digit enables, active-low one-hot; bit 0 = ones digit.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low; constant 1 (off).

## Operation

- **Converter FSM: IDLE, CONVERT, DONE.**
  - IDLE: at the next edge, capture `value` into a 12-bit shift register, clear the 16-bit scratch, set iter=0, and go to CONVERT.
  - CONVERT: each edge, add 3 to every scratch nibble ≥ 5, then shift {scratch, shift reg} left 1 and increment iter. After the 12th shift, go to DONE.
  - DONE: load `bcd` from scratch, pulse `valid`, and return to IDLE.
- Conversion runs back-to-back forever. Period is 14 cycles: IDLE 1, CONVERT 12, DONE 1.
- `value` is sampled only on the IDLE edge. Changes during CONVERT or DONE are ignored until the next sample.
- Upstream wrap 4095→0 appears at the next conversion. No special handling is required.
- Maximum input is 4095, so the thousands nibble is ≤ 4 and no nibble ever exceeds 9.
- **Scanner:**
  - A refresh counter runs 0..REFRESH_DIV−1 and wraps.
  - On wrap, the digit index advances 0→1→2→3→0.
  - The scanner is independent of the converter.
- **Display registers:**
  - `an` and `seg` are registered every cycle from the current digit index and the current `bcd`.
  - `an` = all ones except bit[index] = 0.
- **Segment codes** (index → `seg`):
  - 0 → 1000000, 1 → 1111001, 2 → 0100100, 3 → 0110000, 4 → 0011001
  - 5 → 0010010, 6 → 0000010, 7 → 1111000, 8 → 0000000, 9 → 0010000
  - blank → 1111111
- **Leading-zero blanking** (BLANK_LEADING=1):
  - Digit 3 is blank if it is 0.
  - Digit 2 is blank if digits 3 and 2 are both 0.
  - Digit 1 is blank if digits 3..1 are all 0.
  - Digit 0 is never blanked.

## Timing

- **Reset values while `reset`=0** (take effect immediately, independent of `clk`):
  - state IDLE, `bcd`=16'h0000, `valid`=0, `busy`=0
  - refresh counter 0, digit index 0
  - `an`=4'b1110, `seg`=7'b1000000, `dp`=1
- After reset deasserts, the first rising edge is the first IDLE sample edge (E0).
- Conversion edge timing:
  - Shifts occur on E1..E12.
  - `bcd` updates and `valid` rises on E13; `valid` falls on E14.
  - E14 is the next sample edge.
- Latency from sample edge to `bcd` is 13 cycles. `valid` recurs every 14 cycles.
- `busy` is high during CONVERT and DONE: it rises on E0 and falls on E13, so it is low only during IDLE cycles.
- `an`/`seg` lag the digit index and `bcd` by one cycle. Both update on the same edge, so there is no mixed-digit cycle.
- Simultaneous `bcd` update and digit advance: the new digit shows the new `bcd` one edge later.
- Reset asserted mid-conversion aborts it. The partial result is discarded and `bcd` returns to 0.

## Test plan

- **Reset:** hold `reset`=0 with `value`=1234 for 10 cycles.
  - Expect `bcd`=0, `valid`=0, `busy`=0, `an`=1110, `seg`=1000000, `dp`=1 throughout.
- **Basic conversion:** release reset with `value`=1234 held.
  - Expect `valid` high exactly on cycles 13, 27, 41 after E0, with `bcd`=16'h1234 from the first pulse.
- **Range ends:**
  - `value`=4095 → `bcd`=16'h4095.
  - `value`=0 → `bcd`=16'h0000; digits 3..1 show `seg`=1111111 and digit 0 shows 1000000.
- **Scan order** (REFRESH_DIV=4, `value`=907):
  - `an` cycles 1110, 1101, 1011, 0111, 4 cycles each.
  - `seg` follows 1111000, 1000000, 0010000, 1111111.
- **Mid-conversion change:** `value`=100, then change to 200 on cycle 5 of CONVERT.
  - Expect the next `bcd`=16'h0100, then 16'h0200 on the following conversion.
- **Reset mid-operation:** assert `reset` at cycle 7 of CONVERT, between clock edges.
  - Outputs must reach reset values before the next edge.
  - After release, the first `valid` occurs 13 cycles after E0.

Source files
------------

// File: rtl/count_display.sv
// Display stage for the 12-bit counter: sequential double-dabble binary-to-BCD
// converter feeding a 4-digit active-low multiplexed seven-segment scanner.
module count_display #(
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] value,
  output logic [15:0] bcd,
  output logic        valid,
  output logic        busy,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StConvert, StDone} state_e;

  state_e         state_q;
  logic [11:0]    shift_q;
  logic [15:0]    scratch_q;
  logic [3:0]     iter_q;
  logic [15:0]    scratch_adj;

  logic [CntW-1:0] refresh_q;
  logic [1:0]      digit_q;
  logic [3:0]      nibble;
  logic            blank;
  logic [6:0]      seg_d;
  logic [3:0]      an_d;

  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      bcd       <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        StIdle: begin
          shift_q   <= value;
          scratch_q <= '0;
          iter_q    <= '0;
          busy      <= 1'b1;
          state_q   <= StConvert;
        end
        StConvert: begin
          // Thousands never exceeds 4, so its corrected MSB is always zero.
          {scratch_q, shift_q} <= {scratch_adj[14:0], shift_q, 1'b0};
          iter_q <= iter_q + 4'd1;
          if (iter_q == 4'd11) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          bcd     <= scratch_q;
          valid   <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_q <= '0;
      digit_q   <= '0;
    end else if (refresh_q == CntW'(REFRESH_DIV - 1)) begin
      refresh_q <= '0;
      digit_q   <= digit_q + 2'd1;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

  always_comb begin
    nibble = bcd[4*digit_q +: 4];
    blank  = 1'b0;
    if (BLANK_LEADING != 0) begin
      unique case (digit_q)
        2'd3:    blank = (bcd[15:12] == 4'd0);
        2'd2:    blank = (bcd[15:8] == 8'd0);
        2'd1:    blank = (bcd[15:4] == 12'd0);
        default: blank = 1'b0;
      endcase
    end
    an_d = ~(4'b0001 << digit_q);
    if (blank) begin
      seg_d = 7'b1111111;
    end else begin
      case (nibble)
        4'd0:    seg_d = 7'b1000000;
        4'd1:    seg_d = 7'b1111001;
        4'd2:    seg_d = 7'b0100100;
        4'd3:    seg_d = 7'b0110000;
        4'd4:    seg_d = 7'b0011001;
        4'd5:    seg_d = 7'b0010010;
        4'd6:    seg_d = 7'b0000010;
        4'd7:    seg_d = 7'b1111000;
        4'd8:    seg_d = 7'b0000000;
        4'd9:    seg_d = 7'b0010000;
        default: seg_d = 7'b1111111;
      endcase
    end
  end

  // an and seg share one register stage so a digit never shows mixed data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= 4'b1110;
      seg <= 7'b1000000;
    end else begin
      an  <= an_d;
      seg <= seg_d;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_count_display.sv
// Self-checking bench for count_display: scoreboard of expected BCD values
// pushed at each sample edge and popped on every valid pulse.
module tb_count_display;

  localparam int unsigned RefreshDiv = 4;

  logic        clk;
  logic        reset;
  logic [11:0] value;
  logic [15:0] bcd;
  logic        valid;
  logic        busy;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int unsigned n_vec;
  int unsigned n_fail;
  int unsigned k;
  bit          running;
  logic [15:0] sb[$];

  count_display #(
    .REFRESH_DIV  (RefreshDiv),
    .BLANK_LEADING(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .value(value),
    .bcd  (bcd),
    .valid(valid),
    .busy (busy),
    .an   (an),
    .seg  (seg),
    .dp   (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // One clock edge; k counts edges since reset release (E0 = 0).
  task automatic tick();
    logic [15:0] exp_bcd;
    if (running && (k % 14 == 0)) sb.push_back(to_bcd(int'(value)));
    @(posedge clk);
    #1;
    if (running) begin
      n_vec++;
      if (valid !== (k % 14 == 13)) begin
        n_fail++;
        $display("FAIL valid_phase: edge %0d valid=%b want %b", k, valid, (k % 14 == 13));
      end
      if (valid === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_empty: edge %0d bcd=%h with no expected value", k, bcd);
        end else begin
          exp_bcd = sb.pop_front();
          if (bcd !== exp_bcd) begin
            n_fail++;
            $display("FAIL sb_bcd: edge %0d bcd=%h want %h", k, bcd, exp_bcd);
          end
        end
      end
      k++;
    end
  endtask

  task automatic release_reset();
    reset   = 1'b1;
    running = 1'b1;
    k       = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    value = 12'd1234;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if ({bcd, valid, busy, an, seg, dp} !== {16'h0000, 1'b0, 1'b0, 4'b1110, 7'b1000000, 1'b1}) begin
        n_fail++;
        $display("FAIL reset_vals: bcd=%h valid=%b busy=%b an=%b seg=%b dp=%b", bcd, valid, busy,
                 an, seg, dp);
      end
    end
  endtask

  task automatic test_basic();
    int unsigned nvalid;
    nvalid = 0;
    release_reset();
    for (int i = 0; i < 42; i++) begin
      tick();
      if (valid === 1'b1) nvalid++;
      if (k - 1 == 0) begin
        n_vec++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_rise: busy=%b want 1 after E0", busy);
        end
      end
      if (k - 1 == 13) begin
        n_vec++;
        if (bcd !== 16'h1234 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_bcd: bcd=%h busy=%b want 1234/0", bcd, busy);
        end
      end
    end
    n_vec++;
    if (nvalid != 3) begin
      n_fail++;
      $display("FAIL basic_count: %0d valid pulses want 3", nvalid);
    end
  endtask

  task automatic test_range();
    int unsigned idx;
    value = 12'd4095;
    for (int i = 0; i < 28; i++) tick();
    n_vec++;
    if (bcd !== 16'h4095) begin
      n_fail++;
      $display("FAIL range_max: bcd=%h want 4095", bcd);
    end
    value = 12'd0;
    for (int i = 0; i < 28; i++) tick();
    n_vec++;
    if (bcd !== 16'h0000) begin
      n_fail++;
      $display("FAIL range_zero: bcd=%h want 0000", bcd);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      idx = ((k - 1) / RefreshDiv) % 4;
      n_vec++;
      if (an !== ~(4'b0001 << idx) || seg !== ((idx == 0) ? 7'b1000000 : 7'b1111111)) begin
        n_fail++;
        $display("FAIL zero_blank: digit %0d an=%b seg=%b", idx, an, seg);
      end
    end
  endtask

  task automatic test_scan();
    int unsigned idx;
    logic [6:0] exp_seg[4];
    exp_seg[0] = 7'b1111000;
    exp_seg[1] = 7'b1000000;
    exp_seg[2] = 7'b0010000;
    exp_seg[3] = 7'b1111111;
    value = 12'd907;
    for (int i = 0; i < 28; i++) tick();
    n_vec++;
    if (bcd !== 16'h0907) begin
      n_fail++;
      $display("FAIL scan_bcd: bcd=%h want 0907", bcd);
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      idx = ((k - 1) / RefreshDiv) % 4;
      n_vec++;
      if (an !== ~(4'b0001 << idx) || seg !== exp_seg[idx] || dp !== 1'b1) begin
        n_fail++;
        $display("FAIL scan: digit %0d an=%b seg=%b dp=%b want %b %b 1", idx, an, seg, dp,
                 ~(4'b0001 << idx), exp_seg[idx]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 14 && (k % 14) != 0; i++) tick();
    value = 12'd100;
    tick();
    for (int i = 0; i < 4; i++) tick();
    value = 12'd200;
    for (int i = 0; i < 9; i++) tick();
    n_vec++;
    if (bcd !== 16'h0100 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midchange_first: bcd=%h valid=%b want 0100/1", bcd, valid);
    end
    for (int i = 0; i < 14; i++) tick();
    n_vec++;
    if (bcd !== 16'h0200 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midchange_second: bcd=%h valid=%b want 0200/1", bcd, valid);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned first_valid;
    for (int i = 0; i < 14 && (k % 14) != 0; i++) tick();
    tick();
    for (int i = 0; i < 6; i++) tick();
    #2;
    reset = 1'b0;
    running = 1'b0;
    sb.delete();
    #1;
    n_vec++;
    if ({bcd, valid, busy, an, seg, dp} !== {16'h0000, 1'b0, 1'b0, 4'b1110, 7'b1000000, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_async: bcd=%h valid=%b busy=%b an=%b seg=%b dp=%b", bcd, valid, busy,
               an, seg, dp);
    end
    tick();
    tick();
    release_reset();
    first_valid = 999;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid === 1'b1 && first_valid == 999) first_valid = k - 1;
    end
    n_vec++;
    if (first_valid != 13) begin
      n_fail++;
      $display("FAIL reset_mid_latency: first valid at edge %0d want 13", first_valid);
    end
  endtask

  initial begin
    n_vec   = 0;
    n_fail  = 0;
    k       = 0;
    running = 1'b0;
    test_reset();
    test_basic();
    test_range();
    test_scan();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
